// File: rtl/vm_request_arbiter.sv
// Purpose : shares one clocked vending-machine core between two requesters (round-robin, req/ack).
// Latency : grant edge k -> ack high in cycle k+1, result (rsp_valid) in cycle k+3; one txn per 3 cycles.
// Backpress: requesters hold req until ack; a requester is ignored for COOLDOWN cycles after a failed buy.
//
// Ports:
//   CLK, RST                  clock and synchronous active-high reset
//   reqN/moneyN/vmN/pidN/sugarN  request and payload from requester N (N = 0,1)
//   ackN                      one-cycle grant pulse, payload captured onto core_*
//   rsp_valid/owner/money/item/flags  shared result bus, data held until next capture
//   core_money/vm/pid/sugar   stimulus to the vending core (idle code outside ISSUE)
//   core_moneyLeft/itemLeft/flags  registered outputs of the vending core
module vm_request_arbiter #(
    parameter int          MONEY_W  = 6,
    parameter int          ITEM_W   = 5,
    parameter logic [2:0]  IDLE_PID = 3'b111,
    parameter int          COOLDOWN = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req0,
    input  logic               req1,
    input  logic [MONEY_W-1:0] money0,
    input  logic [MONEY_W-1:0] money1,
    input  logic               vm0,
    input  logic               vm1,
    input  logic [2:0]         pid0,
    input  logic [2:0]         pid1,
    input  logic               sugar0,
    input  logic               sugar1,
    output logic               ack0,
    output logic               ack1,
    output logic               rsp_valid,
    output logic               rsp_owner,
    output logic [MONEY_W-1:0] rsp_money,
    output logic [ITEM_W-1:0]  rsp_item,
    output logic [5:0]         rsp_flags,
    output logic [MONEY_W-1:0] core_money,
    output logic               core_vm,
    output logic [2:0]         core_pid,
    output logic               core_sugar,
    input  logic [MONEY_W-1:0] core_moneyLeft,
    input  logic [ITEM_W-1:0]  core_itemLeft,
    input  logic [5:0]         core_flags
);

    // Counter width must stay at least 1 bit even when cooldown is disabled.
    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE
    } state_t;

    state_t          state;
    logic            last_grant;
    logic            owner;
    logic [CD_W-1:0] cooldown [2];

    logic elig0;
    logic elig1;
    logic pick1;

    always_comb begin
        elig0 = req0 && (cooldown[0] == '0);
        elig1 = req1 && (cooldown[1] == '0);
        // On a tie the requester that did not win last time goes next.
        pick1 = elig1 && (!elig0 || !last_grant);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_owner  <= 1'b0;
            rsp_money  <= '0;
            rsp_item   <= '0;
            rsp_flags  <= '0;
            core_money <= '0;
            core_vm    <= 1'b0;
            core_pid   <= IDLE_PID;
            core_sugar <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (elig0 || elig1) begin
                        owner      <= pick1;
                        last_grant <= pick1;
                        ack0       <= !pick1;
                        ack1       <= pick1;
                        core_money <= pick1 ? money1 : money0;
                        core_vm    <= pick1 ? vm1    : vm0;
                        core_pid   <= pick1 ? pid1   : pid0;
                        core_sugar <= pick1 ? sugar1 : sugar0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The core samples the payload at this edge; return to the
                    // non-purchasing idle code straight after so stock cannot move.
                    core_money <= '0;
                    core_vm    <= 1'b0;
                    core_pid   <= IDLE_PID;
                    core_sugar <= 1'b0;
                    state      <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    rsp_valid <= 1'b1;
                    rsp_owner <= owner;
                    rsp_money <= core_moneyLeft;
                    rsp_item  <= core_itemLeft;
                    rsp_flags <= core_flags;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Loaded on the capture edge so the failing requester is already blocked
    // at the first arbitration edge after its result appears.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                cooldown[i] <= '0;
            end else if (state == S_CAPTURE && !core_flags[5] && owner == 1'(i)) begin
                cooldown[i] <= CD_W'(COOLDOWN);
            end else if (cooldown[i] != '0) begin
                cooldown[i] <= cooldown[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vm_request_arbiter.sv
module tb_vm_request_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       req0, req1;
    logic [5:0] money0, money1;
    logic       vm0, vm1, sugar0, sugar1;
    logic [2:0] pid0, pid1;
    logic       ack0, ack1, rsp_valid, rsp_owner;
    logic [5:0] rsp_money;
    logic [4:0] rsp_item;
    logic [5:0] rsp_flags;
    logic [5:0] core_money;
    logic       core_vm, core_sugar;
    logic [2:0] core_pid;
    logic [5:0] core_moneyLeft = '0;
    logic [4:0] core_itemLeft  = '0;
    logic [5:0] core_flags     = '0;

    always #5 CLK = ~CLK;

    vm_request_arbiter dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .money0(money0), .money1(money1),
        .vm0(vm0), .vm1(vm1), .pid0(pid0), .pid1(pid1),
        .sugar0(sugar0), .sugar1(sugar1), .ack0(ack0), .ack1(ack1),
        .rsp_valid(rsp_valid), .rsp_owner(rsp_owner), .rsp_money(rsp_money),
        .rsp_item(rsp_item), .rsp_flags(rsp_flags), .core_money(core_money),
        .core_vm(core_vm), .core_pid(core_pid), .core_sugar(core_sugar),
        .core_moneyLeft(core_moneyLeft), .core_itemLeft(core_itemLeft),
        .core_flags(core_flags)
    );

    typedef struct packed {logic [5:0] money; logic vm; logic [2:0] pid; logic sugar;} pay_t;
    typedef struct packed {logic [5:0] money; logic [4:0] item; logic [5:0] flags;} res_t;
    typedef struct packed {logic owner; logic [5:0] money; logic [4:0] item; logic [5:0] flags;} exp_t;

    pay_t q0[$], q1[$];
    exp_t sb[$];
    int   ack_log[$];
    pay_t cur0 = '0, cur1 = '0;
    int   n_checks = 0, n_fail = 0, cyc = 0;
    int   core_stk[8], ref_stk[8];
    int   last_ack_cyc[2], block_until[2];
    int   fail_rsp_cyc = 0;
    logic [5:0] fail_money = '0, fail_flags = '0;
    logic [5:0] last_money = '0, last_flags = '0;
    logic [4:0] last_item = '0;
    logic prev_ack0 = 1'b0, prev_ack1 = 1'b0;

    assign money0 = cur0.money; assign vm0 = cur0.vm; assign pid0 = cur0.pid; assign sugar0 = cur0.sugar;
    assign money1 = cur1.money; assign vm1 = cur1.vm; assign pid1 = cur1.pid; assign sugar1 = cur1.sugar;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Vending core behaviour: VM0 {20,10,5}, VM1 {12,15}; anything else invalid.
    function automatic int price(input logic vm, input logic [2:0] pid);
        if (!vm) return (pid == 3'd0) ? 20 : (pid == 3'd1) ? 10 : (pid == 3'd2) ? 5 : 0;
        return (pid == 3'd0) ? 12 : (pid == 3'd1) ? 15 : 0;
    endfunction

    function automatic res_t vend(input logic vm, input logic [2:0] pid, input logic [5:0] money,
                                  input logic sugar, input int stk);
        int p;
        p = price(vm, pid);
        if (p == 0)             return '{money, 5'd0, 6'b001000};
        if (!vm && sugar)       return '{money, 5'd0, 6'b010000};
        if (stk == 0)           return '{money, 5'd0, 6'b000001};
        if (int'(money) < p)    return '{money, 5'(stk), 6'b000010};
        return '{6'(int'(money) - p), 5'(stk - 1), 6'b100000};
    endfunction

    initial for (int i = 0; i < 8; i++) begin core_stk[i] = 10; ref_stk[i] = 10; end
    initial begin last_ack_cyc[0] = 0; last_ack_cyc[1] = 0; block_until[0] = 0; block_until[1] = 0; end

    always @(posedge CLK) cyc <= cyc + 1;

    // Clocked core model; not reset by RST.
    always @(posedge CLK) begin : core_model
        automatic int   idx = int'({core_vm, core_pid[1:0]});
        automatic res_t r   = vend(core_vm, core_pid, core_money, core_sugar, core_stk[idx]);
        if (r.flags[5]) core_stk[idx] <= core_stk[idx] - 1;
        core_moneyLeft <= r.money;
        core_itemLeft  <= r.item;
        core_flags     <= r.flags;
    end

    task automatic take(input logic owner, input pay_t p);
        automatic int idx = int'({p.vm, p.pid[1:0]});
        res_t r;
        check("grant_core_money", core_money, p.money);
        check("grant_core_pid", core_pid, p.pid);
        check("grant_core_vm", core_vm, p.vm);
        check("grant_core_sugar", core_sugar, p.sugar);
        check("cooldown_respected", cyc >= block_until[owner], 1);
        r = vend(p.vm, p.pid, p.money, p.sugar, ref_stk[idx]);
        if (r.flags[5]) ref_stk[idx]--;
        sb.push_back('{owner, r.money, r.item, r.flags});
        ack_log.push_back(int'(owner));
        last_ack_cyc[owner] = cyc;
    endtask

    // Requester drivers: hold req until ack, then present the next queued request.
    initial begin
        req0 = 1'b0; req1 = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (ack0) begin
                take(1'b0, cur0);
                if (q0.size() > 0) cur0 = q0.pop_front(); else req0 = 1'b0;
            end else if (!req0 && q0.size() > 0) begin
                cur0 = q0.pop_front(); req0 = 1'b1;
            end
            if (ack1) begin
                take(1'b1, cur1);
                if (q1.size() > 0) cur1 = q1.pop_front(); else req1 = 1'b0;
            end else if (!req1 && q1.size() > 0) begin
                cur1 = q1.pop_front(); req1 = 1'b1;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    initial forever begin
        @(negedge CLK);
        if (!RST) begin
            if (!ack0 && !ack1) begin
                check("idle_core_pid", core_pid, 3'b111);
                check("idle_core_money", core_money, 0);
            end else begin
                check("ack_onehot", ack0 & ack1, 0);
            end
            if (ack0) check("ack0_pulse", prev_ack0, 0);
            if (ack1) check("ack1_pulse", prev_ack1, 0);
            if (rsp_valid) begin
                check("rsp_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    automatic exp_t e = sb.pop_front();
                    check("rsp_owner", rsp_owner, e.owner);
                    check("rsp_money", rsp_money, e.money);
                    check("rsp_item", rsp_item, e.item);
                    check("rsp_flags", rsp_flags, e.flags);
                    check("rsp_latency", cyc - last_ack_cyc[e.owner], 2);
                    if (!e.flags[5]) begin
                        block_until[e.owner] = cyc + 5;
                        fail_rsp_cyc = cyc;
                        fail_money = rsp_money;
                        fail_flags = rsp_flags;
                    end
                end
                last_money = rsp_money; last_item = rsp_item; last_flags = rsp_flags;
            end
        end
        prev_ack0 = ack0; prev_ack1 = ack1;
    end

    task automatic wait_drain(input string tag, input int budget);
        int t;
        t = 0;
        while ((q0.size() > 0 || q1.size() > 0 || req0 || req1 || sb.size() > 0) && t < budget) begin
            @(negedge CLK); t++;
        end
        check(tag, t < budget, 1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"}, ack0, 0);
        check({tag, "_ack1"}, ack1, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_owner"}, rsp_owner, 0);
        check({tag, "_rsp_money"}, rsp_money, 0);
        check({tag, "_rsp_item"}, rsp_item, 0);
        check({tag, "_rsp_flags"}, rsp_flags, 0);
        check({tag, "_core_money"}, core_money, 0);
        check({tag, "_core_vm"}, core_vm, 0);
        check({tag, "_core_pid"}, core_pid, 3'b111);
        check({tag, "_core_sugar"}, core_sugar, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        int   n;
        logic [4:0] item_a;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);

        // 1: single sandwich purchase
        q0.push_back('{6'd20, 1'b0, 3'd0, 1'b0});
        wait_drain("t1_drain", 50);
        check("t1_money", last_money, 0);
        check("t1_item", last_item, 9);
        check("t1_flags", last_flags, 6'b100000);

        // 2: both requesters busy, grants alternate starting with requester 0
        ack_log.delete();
        q0.push_back('{6'd10, 1'b0, 3'd1, 1'b0});
        q0.push_back('{6'd12, 1'b0, 3'd1, 1'b0});
        @(negedge CLK);
        q1.push_back('{6'd15, 1'b1, 3'd0, 1'b1});
        q1.push_back('{6'd20, 1'b1, 3'd1, 1'b0});
        wait_drain("t2_drain", 100);
        check("t2_ack_count", ack_log.size(), 4);
        for (int i = 0; i < ack_log.size(); i++) check("t2_ack_order", ack_log[i], i % 2);

        // 3: idle period keeps the idle code on the core; stock unaffected
        q0.push_back('{6'd5, 1'b0, 3'd2, 1'b0});
        wait_drain("t3_drain_a", 50);
        item_a = last_item;
        repeat (20) @(negedge CLK);
        q0.push_back('{6'd5, 1'b0, 3'd2, 1'b0});
        wait_drain("t3_drain_b", 50);
        check("t3_item_dec", last_item, item_a - 5'd1);

        // 4: invalid product on requester 1 triggers cooldown while req0 is served
        ack_log.delete();
        q1.push_back('{6'd10, 1'b1, 3'd7, 1'b0});
        q1.push_back('{6'd12, 1'b1, 3'd0, 1'b0});
        q0.push_back('{6'd10, 1'b0, 3'd1, 1'b0});
        wait_drain("t4_drain", 100);
        check("t4_fail_money", fail_money, 10);
        check("t4_fail_flags", fail_flags, 6'b001000);
        check("t4_ack_count", ack_log.size(), 3);
        if (ack_log.size() == 3) begin
            check("t4_ack_first", ack_log[0], 1);
            check("t4_ack_second", ack_log[1], 0);
            check("t4_ack_third", ack_log[2], 1);
        end
        check("t4_regrant_cycle", last_ack_cyc[1], fail_rsp_cyc + 5);

        // 5: reset during ISSUE abandons the transaction; core stock change stands
        q0.push_back('{6'd10, 1'b0, 3'd1, 1'b0});
        t = 0;
        while (!ack0 && t < 30) begin @(negedge CLK); t++; end
        check("t5_ack_seen", ack0, 1);
        RST = 1'b1;
        sb.delete();
        @(negedge CLK);
        check_reset_outputs("t5_reset");
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        q0.push_back('{6'd10, 1'b0, 3'd1, 1'b0});
        wait_drain("t5_drain", 50);
        check("t5_flags", last_flags, 6'b100000);

        // 6: deplete sandwiches, then a failed buy applies cooldown
        n = ref_stk[0];
        for (int i = 0; i < n; i++) q0.push_back('{6'd20, 1'b0, 3'd0, 1'b0});
        wait_drain("t6_deplete", 60 * (n + 1));
        q0.push_back('{6'd20, 1'b0, 3'd0, 1'b0});
        q0.push_back('{6'd5, 1'b0, 3'd2, 1'b0});
        wait_drain("t6_drain", 100);
        check("t6_fail_money", fail_money, 20);
        check("t6_fail_flags", fail_flags, 6'b000001);
        check("t6_regrant_cycle", last_ack_cyc[0], fail_rsp_cyc + 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
